pong_game_sequencer: RTL and testbench
======================================

Name: pong_game_sequencer

Overview:
- Game-state controller for the pong display path.
- Owns ball position and direction, both paddle positions, scores and game phase.
- Advances the game once per video frame, during vertical blanking, so the pixel renderer only ever sees stable coordinates during active video.
- Sits between the VGA timing generator (Vsync) and the pixel renderer; it is clocked by the 25 MHz pixel clock.

Parameters:
- V_ACTIVE, 480, active lines
- H_ACTIVE, 640, active pixels per line
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_H, 64, paddle height
- PADDLE_W, 8, paddle width
- LEFT_PADDLE_X, 16, left paddle left edge
- RIGHT_PADDLE_X, 616, right paddle left edge
- PADDLE_STEP, 4, paddle pixels per frame
- BALL_STEP, 2, ball pixels per frame, per axis
- SERVE_FRAMES, 60, frames the ball is held before each serve
- WIN_SCORE, 9, points that end the game

Ports:
- PixelClock  in  1  sole clock
- Reset  in  1  synchronous, active-high
- Vsync  in  1  VGA vertical sync, active low
- Start  in  1  level; its rising edge starts or restarts the game
- Pause  in  1  level; freezes play
- KeyLUp, KeyLDown, KeyRUp, KeyRDown  in  1 each  paddle controls, level
- BallX, BallY  out  10  ball top-left corner
- PaddleLY, PaddleRY  out  10  paddle top edges
- ScoreL, ScoreR  out  4  scores
- State  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4
- GameOver  out  1  high in GAMEOVER

Behaviour:
Reset values (all registered):
- State IDLE
- BallX = H_ACTIVE/2 - BALL_SIZE/2 = 316; BallY = V_ACTIVE/2 - BALL_SIZE/2 = 236
- PaddleLY = PaddleRY = (V_ACTIVE - PADDLE_H)/2 = 208
- Scores 0; direction dx = right, dy = down; serve counter 0; edge registers 0
- Reset overrides everything, including in mid-game.

Tick and edge detection:
- vs_q <= Vsync every cycle. tick = vs_q & ~Vsync.
- All per-frame updates commit on the same edge where tick is high.
- Start rise = Start & ~start_q, with start_q registered the same way.

Paddles:
- On every tick in SERVE or PLAY (not while paused), each paddle moves independently.
- Up pressed alone: -PADDLE_STEP. Down pressed alone: +PADDLE_STEP. Both pressed or none: hold.
- Clamp to the range 0 .. V_ACTIVE - PADDLE_H (416). Use wider or saturating arithmetic; no wrap-around is allowed.

States:
- IDLE: Start rise -> SERVE; serve counter cleared; scores cleared.
- SERVE:
  - Ball held at the centre.
  - Each tick increments the counter.
  - On the tick where the counter reaches SERVE_FRAMES -> PLAY. The ball does not move on that tick.
- PLAY, on each tick with Pause low; ball collision checks use the pre-tick paddle values:
  - Y axis:
    - Moving up with BallY <= BALL_STEP: BallY = 0, dy = down.
    - Moving down with BallY >= V_ACTIVE - BALL_SIZE - BALL_STEP: BallY = 472, dy = up.
    - Otherwise BallY += or -= BALL_STEP.
  - X axis, left paddle hit: moving left, BallX >= face (LEFT_PADDLE_X + PADDLE_W = 24), BallX - BALL_STEP <= face, and vertical overlap (BallY + BALL_SIZE > PaddleLY and BallY < PaddleLY + PADDLE_H). Result: BallX = 24, dx = right.
  - X axis, right paddle: mirror of the left case, with face = RIGHT_PADDLE_X - BALL_SIZE = 608.
  - X axis, left miss: moving left with BallX <= BALL_STEP -> POINT, scorer = R; the ball position is left unchanged.
  - X axis, right miss: moving right with BallX >= H_ACTIVE - BALL_SIZE - BALL_STEP -> POINT, scorer = L.
  - X and Y resolve independently in the same tick, so corner cases apply both.
- POINT: lasts exactly one cycle, does not wait for a tick.
  - Scorer's score += 1.
  - Ball recentred; dx points toward the player who lost the point; dy kept; serve counter cleared.
  - If the new score == WIN_SCORE -> GAMEOVER, else -> SERVE.
- GAMEOVER:
  - All positions frozen; ticks ignored.
  - Start rise -> IDLE: scores 0, ball centred, paddles centred.
- Start rise in SERVE or PLAY is ignored.
- Pause high: ticks are ignored in SERVE and PLAY (the counter also freezes). Pause has no effect in other states.

Test Plan:
- Reset -> State 0, BallX 316, BallY 236, both paddles 208, scores 0, GameOver 0.
- Start pulse, then 60 Vsync falls -> State 2 on the 60th tick with the ball still at 316/236; next tick -> BallX 318, BallY 238.
- KeyLUp held 60 ticks from 208 -> PaddleLY reaches 0 at tick 52 and stays at 0; both left keys held -> no change. KeyRDown held -> PaddleRY saturates at 416.
- Ball forced to BallY 1 moving up -> next tick BallY 0 and dy down; following tick BallY 2. Ball meeting the left paddle face at 25 with overlap -> BallX 24, dx right.
- Left paddle away from the ball, ball moving left reaches BallX <= 2 -> POINT for one cycle, ScoreR 1, ball 316/236, dx left, State 1. Pause high for 10 ticks in PLAY -> no movement.
- ScoreR 8, then another left miss -> ScoreR 9, State 4, GameOver 1; Start rise -> State 0, scores 0. Reset asserted mid-PLAY -> all reset values on the next edge.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// Pong game-state controller: owns ball, paddles, scores and game phase,
// advancing the game once per frame on the falling edge of Vsync.
module pong_game_sequencer #(
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned BALL_SIZE      = 8,
    parameter int unsigned PADDLE_H       = 64,
    parameter int unsigned PADDLE_W       = 8,
    parameter int unsigned LEFT_PADDLE_X  = 16,
    parameter int unsigned RIGHT_PADDLE_X = 616,
    parameter int unsigned PADDLE_STEP    = 4,
    parameter int unsigned BALL_STEP      = 2,
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned WIN_SCORE      = 9
) (
    input  logic       PixelClock,
    input  logic       Reset,
    input  logic       Vsync,
    input  logic       Start,
    input  logic       Pause,
    input  logic       KeyLUp,
    input  logic       KeyLDown,
    input  logic       KeyRUp,
    input  logic       KeyRDown,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] PaddleLY,
    output logic [9:0] PaddleRY,
    output logic [3:0] ScoreL,
    output logic [3:0] ScoreR,
    output logic [2:0] State,
    output logic       GameOver
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_POINT    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_e;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned WIDE_W  = COORD_W + 1;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = $clog2(SERVE_FRAMES + 1);

    localparam logic [COORD_W-1:0] BALL_X0    = COORD_W'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [COORD_W-1:0] BALL_Y0    = COORD_W'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [COORD_W-1:0] PAD_Y0     = COORD_W'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [WIDE_W-1:0]  PAD_MAX    = WIDE_W'(V_ACTIVE - PADDLE_H);
    localparam logic [WIDE_W-1:0]  PAD_STEP_W = WIDE_W'(PADDLE_STEP);
    localparam logic [COORD_W-1:0] B_STEP     = COORD_W'(BALL_STEP);
    localparam logic [COORD_W-1:0] B_SIZE     = COORD_W'(BALL_SIZE);
    localparam logic [COORD_W-1:0] P_HEIGHT   = COORD_W'(PADDLE_H);
    localparam logic [COORD_W-1:0] Y_BOT      = COORD_W'(V_ACTIVE - BALL_SIZE);
    localparam logic [COORD_W-1:0] Y_BOT_LIM  = COORD_W'(V_ACTIVE - BALL_SIZE - BALL_STEP);
    localparam logic [COORD_W-1:0] X_RGT_LIM  = COORD_W'(H_ACTIVE - BALL_SIZE - BALL_STEP);
    localparam logic [COORD_W-1:0] FACE_L     = COORD_W'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [COORD_W-1:0] FACE_R     = COORD_W'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] ball_x_q, ball_x_d;
    logic [COORD_W-1:0] ball_y_q, ball_y_d;
    logic               dx_q, dx_d;          // 1 = moving right
    logic               dy_q, dy_d;          // 1 = moving down
    logic [COORD_W-1:0] pad_l_q, pad_l_d;
    logic [COORD_W-1:0] pad_r_q, pad_r_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic               point_l_q, point_l_d; // 1 = left player scored
    logic               game_over_q, game_over_d;
    logic               vs_q, start_q;

    logic tick_c, step_c, start_rise_c;
    logic ovl_l_c, ovl_r_c;
    logic hit_l_c, hit_r_c, miss_l_c, miss_r_c;

    // Saturating paddle move; wide arithmetic so the clamp never sees a wrapped value.
    function automatic logic [COORD_W-1:0] paddle_next(input logic [COORD_W-1:0] y,
                                                       input logic up, input logic dn);
        logic [WIDE_W-1:0] y_w;
        logic [WIDE_W-1:0] res;
        y_w = {1'b0, y};
        res = y_w;
        if (up && !dn) begin
            res = (y_w < PAD_STEP_W) ? '0 : y_w - PAD_STEP_W;
        end else if (dn && !up) begin
            res = ((y_w + PAD_STEP_W) > PAD_MAX) ? PAD_MAX : y_w + PAD_STEP_W;
        end
        return COORD_W'(res);
    endfunction

    // Frame tick, start edge and collision terms, all on pre-tick values.
    always_comb begin
        tick_c       = vs_q & ~Vsync;
        step_c       = tick_c & ~Pause;
        start_rise_c = Start & ~start_q;
        ovl_l_c  = ((ball_y_q + B_SIZE) > pad_l_q) && (ball_y_q < (pad_l_q + P_HEIGHT));
        ovl_r_c  = ((ball_y_q + B_SIZE) > pad_r_q) && (ball_y_q < (pad_r_q + P_HEIGHT));
        hit_l_c  = !dx_q && (ball_x_q >= FACE_L) && ((ball_x_q - B_STEP) <= FACE_L) && ovl_l_c;
        hit_r_c  = dx_q && (ball_x_q <= FACE_R) && ((ball_x_q + B_STEP) >= FACE_R) && ovl_r_c;
        miss_l_c = !dx_q && (ball_x_q <= B_STEP);
        miss_r_c = dx_q && (ball_x_q >= X_RGT_LIM);
    end

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        pad_l_d     = pad_l_q;
        pad_r_d     = pad_r_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_cnt_d = serve_cnt_q;
        point_l_d   = point_l_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise_c) begin
                    state_d     = S_SERVE;
                    serve_cnt_d = '0;
                    score_l_d   = '0;
                    score_r_d   = '0;
                end
            end
            S_SERVE: begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                if (step_c) begin
                    pad_l_d     = paddle_next(pad_l_q, KeyLUp, KeyLDown);
                    pad_r_d     = paddle_next(pad_r_q, KeyRUp, KeyRDown);
                    serve_cnt_d = serve_cnt_q + CNT_ONE;
                    if (serve_cnt_d == SERVE_LAST) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (step_c) begin
                    pad_l_d = paddle_next(pad_l_q, KeyLUp, KeyLDown);
                    pad_r_d = paddle_next(pad_r_q, KeyRUp, KeyRDown);
                    if (!dy_q && (ball_y_q <= B_STEP)) begin
                        ball_y_d = '0;
                        dy_d     = 1'b1;
                    end else if (dy_q && (ball_y_q >= Y_BOT_LIM)) begin
                        ball_y_d = Y_BOT;
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = dy_q ? ball_y_q + B_STEP : ball_y_q - B_STEP;
                    end
                    if (hit_l_c) begin
                        ball_x_d = FACE_L;
                        dx_d     = 1'b1;
                    end else if (hit_r_c) begin
                        ball_x_d = FACE_R;
                        dx_d     = 1'b0;
                    end else if (miss_l_c) begin
                        state_d   = S_POINT;
                        point_l_d = 1'b0;
                    end else if (miss_r_c) begin
                        state_d   = S_POINT;
                        point_l_d = 1'b1;
                    end else begin
                        ball_x_d = dx_q ? ball_x_q + B_STEP : ball_x_q - B_STEP;
                    end
                end
            end
            S_POINT: begin
                ball_x_d    = BALL_X0;
                ball_y_d    = BALL_Y0;
                serve_cnt_d = '0;
                // Serve toward the player who just lost the point.
                dx_d        = point_l_q;
                if (point_l_q) begin
                    score_l_d = score_l_q + SCORE_ONE;
                    state_d   = (score_l_d == WIN) ? S_GAMEOVER : S_SERVE;
                end else begin
                    score_r_d = score_r_q + SCORE_ONE;
                    state_d   = (score_r_d == WIN) ? S_GAMEOVER : S_SERVE;
                end
            end
            S_GAMEOVER: begin
                if (start_rise_c) begin
                    state_d   = S_IDLE;
                    score_l_d = '0;
                    score_r_d = '0;
                    ball_x_d  = BALL_X0;
                    ball_y_d  = BALL_Y0;
                    pad_l_d   = PAD_Y0;
                    pad_r_d   = PAD_Y0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        game_over_d = (state_d == S_GAMEOVER);
    end

    // State registers.
    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            pad_l_q     <= PAD_Y0;
            pad_r_q     <= PAD_Y0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_cnt_q <= '0;
            point_l_q   <= 1'b0;
            game_over_q <= 1'b0;
            vs_q        <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            pad_l_q     <= pad_l_d;
            pad_r_q     <= pad_r_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_cnt_q <= serve_cnt_d;
            point_l_q   <= point_l_d;
            game_over_q <= game_over_d;
            vs_q        <= Vsync;
            start_q     <= Start;
        end
    end

    assign BallX    = ball_x_q;
    assign BallY    = ball_y_q;
    assign PaddleLY = pad_l_q;
    assign PaddleRY = pad_r_q;
    assign ScoreL   = score_l_q;
    assign ScoreR   = score_r_q;
    assign State    = state_q;
    assign GameOver = game_over_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: random and directed frames checked against an
// integer game model that applies the rules one frame at a time.
module tb_pong_game_sequencer;

    logic       PixelClock;
    logic       Reset, Vsync, Start, Pause;
    logic       KeyLUp, KeyLDown, KeyRUp, KeyRDown;
    logic [9:0] BallX, BallY, PaddleLY, PaddleRY;
    logic [3:0] ScoreL, ScoreR;
    logic [2:0] State;
    logic       GameOver;

    int total = 0;
    int bad   = 0;

    // Model state (plain integers; directions are +1/-1).
    int m_ph, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt;
    bit m_r_scored;

    logic [51:0] mid_obs, mid_exp;

    pong_game_sequencer dut (
        .PixelClock(PixelClock), .Reset(Reset), .Vsync(Vsync), .Start(Start),
        .Pause(Pause), .KeyLUp(KeyLUp), .KeyLDown(KeyLDown), .KeyRUp(KeyRUp),
        .KeyRDown(KeyRDown), .BallX(BallX), .BallY(BallY), .PaddleLY(PaddleLY),
        .PaddleRY(PaddleRY), .ScoreL(ScoreL), .ScoreR(ScoreR), .State(State),
        .GameOver(GameOver)
    );

    initial PixelClock = 1'b0;
    always #5 PixelClock = ~PixelClock;

    function automatic logic [51:0] obs_vec();
        return {State, BallX, BallY, PaddleLY, PaddleRY, ScoreL, ScoreR, GameOver};
    endfunction

    function automatic logic [51:0] exp_vec();
        return {3'(m_ph), 10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr),
                4'(m_sl), 4'(m_sr), (m_ph == 4)};
    endfunction

    function automatic int clamp_pad(input int y);
        if (y < 0) return 0;
        if (y > 416) return 416;
        return y;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_cnt = 0; m_r_scored = 0;
    endtask

    task automatic m_start();
        if (m_ph == 0) begin
            m_ph = 1; m_cnt = 0; m_sl = 0; m_sr = 0;
        end else if (m_ph == 4) begin
            m_ph = 0; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
        end
    endtask

    // One frame of game rules; collisions look at the pre-frame ball and paddles.
    task automatic m_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit pz);
        int opl, opr, obx, oby;
        if ((m_ph == 1 || m_ph == 2) && !pz) begin
            opl = m_pl; opr = m_pr; obx = m_bx; oby = m_by;
            m_pl = clamp_pad(m_pl + 4 * (int'(ld) - int'(lu)));
            m_pr = clamp_pad(m_pr + 4 * (int'(rd) - int'(ru)));
            if (m_ph == 1) begin
                m_cnt++;
                if (m_cnt == 60) m_ph = 2;
            end else begin
                if (m_dy < 0 && oby <= 2) begin m_by = 0; m_dy = 1; end
                else if (m_dy > 0 && oby >= 470) begin m_by = 472; m_dy = -1; end
                else m_by = oby + 2 * m_dy;
                if (m_dx < 0) begin
                    if (obx >= 24 && obx - 2 <= 24 && oby + 8 > opl && oby < opl + 64) begin
                        m_bx = 24; m_dx = 1;
                    end else if (obx <= 2) begin
                        m_ph = 3; m_r_scored = 1;
                    end else m_bx = obx - 2;
                end else begin
                    if (obx <= 608 && obx + 2 >= 608 && oby + 8 > opr && oby < opr + 64) begin
                        m_bx = 608; m_dx = -1;
                    end else if (obx >= 630) begin
                        m_ph = 3; m_r_scored = 0;
                    end else m_bx = obx + 2;
                end
            end
        end
    endtask

    task automatic m_point();
        if (m_r_scored) begin m_sr++; m_dx = -1; end
        else begin m_sl++; m_dx = 1; end
        m_bx = 316; m_by = 236; m_cnt = 0;
        m_ph = (m_sr == 9 || m_sl == 9) ? 4 : 1;
    endtask

    // One video frame: a single Vsync fall, then the cycle after (where POINT resolves).
    task automatic drive_frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit pz);
        KeyLUp = lu; KeyLDown = ld; KeyRUp = ru; KeyRDown = rd; Pause = pz;
        @(negedge PixelClock); Vsync = 1'b0;
        @(negedge PixelClock);
        m_tick(lu, ld, ru, rd, pz);
        mid_obs = obs_vec(); mid_exp = exp_vec();
        Vsync = 1'b1;
        @(negedge PixelClock);
        if (m_ph == 3) m_point();
        @(negedge PixelClock);
    endtask

    task automatic pulse_start();
        @(negedge PixelClock); Start = 1'b1;
        @(negedge PixelClock); Start = 1'b0;
        m_start();
        @(negedge PixelClock);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge PixelClock);
        @(negedge PixelClock);
        Reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        if (BallX !== 10'd316 || BallY !== 10'd236 || PaddleLY !== 10'd208 || GameOver !== 1'b0) begin
            bad++; $display("FAIL reset_values: got %0d/%0d/%0d/%b want 316/236/208/0",
                            BallX, BallY, PaddleLY, GameOver);
        end
    endtask

    task automatic test_serve_and_paddle_clamp();
        pulse_start();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_to_serve: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 1; i <= 60; i++) begin
            drive_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            total++;
            if (mid_obs !== mid_exp) begin
                bad++; $display("FAIL serve_tick%0d: got %h want %h", i, mid_obs, mid_exp);
            end
            if (i == 52) begin
                total++;
                if (PaddleLY !== 10'd0 || PaddleRY !== 10'd416) begin
                    bad++; $display("FAIL paddle_saturate: got %0d/%0d want 0/416", PaddleLY, PaddleRY);
                end
            end
        end
        total++;
        if (State !== 3'd2 || BallX !== 10'd316 || BallY !== 10'd236 || PaddleLY !== 10'd0) begin
            bad++; $display("FAIL serve_to_play: got st=%0d ball=%0d/%0d pl=%0d want st=2 ball=316/236 pl=0",
                            State, BallX, BallY, PaddleLY);
        end
        drive_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (BallX !== 10'd318 || BallY !== 10'd238) begin
            bad++; $display("FAIL first_move: got %0d/%0d want 318/238", BallX, BallY);
        end
    endtask

    task automatic test_both_keys();
        for (int i = 0; i < 10; i++) drive_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            total++;
            if (mid_obs !== mid_exp) begin
                bad++; $display("FAIL both_keys%0d: got %h want %h", i, mid_obs, mid_exp);
            end
        end
        total++;
        if (PaddleLY !== 10'd40 || PaddleRY !== 10'd376) begin
            bad++; $display("FAIL both_keys_hold: got %0d/%0d want 40/376", PaddleLY, PaddleRY);
        end
    endtask

    task automatic test_pause_and_start_ignored();
        int sbx, sby;
        for (int i = 0; i < 400 && m_ph != 2; i++) drive_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sbx = m_bx; sby = m_by;
        for (int i = 0; i < 10; i++) begin
            drive_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            total++;
            if (mid_obs !== mid_exp) begin
                bad++; $display("FAIL pause%0d: got %h want %h", i, mid_obs, mid_exp);
            end
        end
        total++;
        if (BallX !== 10'(sbx) || BallY !== 10'(sby)) begin
            bad++; $display("FAIL pause_frozen: got %0d/%0d want %0d/%0d", BallX, BallY, sbx, sby);
        end
        pulse_start();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_in_play: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random_play();
        for (int i = 0; i < 400; i++) begin
            drive_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0));
            total++;
            if (mid_obs !== mid_exp) begin
                bad++; $display("FAIL rand_tick%0d: got %h want %h", i, mid_obs, mid_exp);
            end
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL rand_post%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    // Left paddle dodges the ball and right paddle chases it, so the right player wins.
    task automatic test_game_to_win();
        int n;
        bit lu, ld, ru, rd;
        n = 0;
        while (m_ph != 4 && n < 8000) begin
            if (m_ph == 0) pulse_start();
            lu = (m_by + 4 >= m_pl + 32);
            ld = !lu;
            ru = (m_by + 4 < m_pr + 32);
            rd = (m_by + 4 > m_pr + 32);
            drive_frame(lu, ld, ru, rd, 1'b0);
            total++;
            if (mid_obs !== mid_exp) begin
                bad++; $display("FAIL game_tick%0d: got %h want %h", n, mid_obs, mid_exp);
            end
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL game_post%0d: got %h want %h", n, obs_vec(), exp_vec());
            end
            n++;
        end
        total++;
        if (State !== 3'd4 || GameOver !== 1'b1 || (ScoreR !== 4'd9 && ScoreL !== 4'd9)) begin
            bad++; $display("FAIL game_over: got st=%0d go=%b scores=%0d/%0d want st=4 go=1 a score of 9",
                            State, GameOver, ScoreL, ScoreR);
        end
        for (int i = 0; i < 3; i++) begin
            drive_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL gameover_frozen%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        pulse_start();
        total++;
        if (State !== 3'd0 || ScoreL !== 4'd0 || ScoreR !== 4'd0 || GameOver !== 1'b0
            || PaddleLY !== 10'd208 || BallX !== 10'd316) begin
            bad++; $display("FAIL restart_idle: got st=%0d sc=%0d/%0d go=%b pl=%0d bx=%0d want 0 0/0 0 208 316",
                            State, ScoreL, ScoreR, GameOver, PaddleLY, BallX);
        end
    endtask

    task automatic test_reset_mid_play();
        pulse_start();
        for (int i = 0; i < 70; i++) drive_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (State !== 3'd2) begin
            bad++; $display("FAIL midplay_reached: got st=%0d want 2", State);
        end
        do_reset();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_mid_play: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        Reset = 1'b1; Vsync = 1'b1; Start = 1'b0; Pause = 1'b0;
        KeyLUp = 1'b0; KeyLDown = 1'b0; KeyRUp = 1'b0; KeyRDown = 1'b0;
        m_reset();
        test_reset();
        test_serve_and_paddle_clamp();
        test_both_keys();
        test_pause_and_start_ignored();
        test_random_play();
        test_game_to_win();
        test_reset_mid_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
